// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and physical memory.
// The arbiter uses the slave view; the surrounding caches/memory use master.
interface cache_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between icache and dcache.
// One transaction at a time; address/op/writeback data are latched on grant
// and held until pmem_resp. Optional macro ARB_RR_EN selects round-robin
// conflict resolution; without it the dcache always wins a conflict.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t            state;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic d_req;
  logic d_wins;

  // A simultaneous read+write from the dcache is a writeback.
  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_RR_EN
  logic last_i;

  // Conflict goes to whichever cache was not granted last.
  assign d_wins = last_i;

  // Remember the owner of every grant; reset to I so the first conflict goes to D.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_i <= 1'b1;
    end else if (state == IDLE) begin
      if (d_req && (!bus.i_read || last_i))
        last_i <= 1'b0;
      else if (bus.i_read)
        last_i <= 1'b1;
    end
  end
`else
  // Fixed priority: dcache stalls the memory stage, so it always wins.
  assign d_wins = 1'b1;
`endif

  // Grant FSM: latch the owner's request on entry, release on pmem_resp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && (!bus.i_read || d_wins)) begin
            state  <= GRANT_D;
            addr_q <= bus.d_addr;
            op_wr  <= bus.d_write;
            if (bus.d_write)
              wdata_q <= bus.d_wdata;
          end else if (bus.i_read) begin
            state  <= GRANT_I;
            addr_q <= bus.i_addr;
            op_wr  <= 1'b0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.pmem_resp)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are a pure decode of registered state, so they are glitch-free.
  assign bus.pmem_read    = (state != IDLE) && !op_wr;
  assign bus.pmem_write   = (state != IDLE) &&  op_wr;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Responses go to the owner only; a resp during the reset cycle is dropped.
  assign bus.i_resp  = rst_n && (state == GRANT_I) && bus.pmem_resp;
  assign bus.d_resp  = rst_n && (state == GRANT_D) && bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus predicts the grant order from
// the arbitration policy and queues expected transactions; a negedge monitor
// pops one per new strobe and checks address/op/data/response routing.
module tb_cache_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t    expq[$];
  exp_t    cur;
  int      n_vec = 0;
  int      n_bad = 0;
  logic    mon_en = 1'b0;
  logic    mem_en = 1'b0;
  logic    prev_stb = 1'b0;
  logic    need_idle = 1'b0;
  logic    stb;
  int      stb_len = 0;
  int      last_len = 0;
  int      i_cnt = 0;
  int      d_cnt = 0;
  logic [LW-1:0] last_rdata = '0;
  logic [LW-1:0] mem_data = '0;
  int      mem_cnt = 0;
  int      mem_lat = 1;
  int      force_lat = 0;
  logic    force_data_en = 1'b0;
  logic [LW-1:0] force_data = '0;
  logic    m_last_i = 1'b1;   // policy model: last cache granted was I

  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chka(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: pop an expectation on each new strobe, check it while it is held.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      stb = bus.pmem_read | bus.pmem_write;
      if (need_idle) begin
        chkb("idle_gap", stb, 1'b0);
        need_idle = 1'b0;
      end
      if (stb && !prev_stb) begin
        stb_len = 0;
        if (expq.size() == 0) begin
          chkb("unexpected_grant", stb, 1'b0);
          cur = '0;
        end else begin
          cur = expq.pop_front();
          chkb("grant_wr", bus.pmem_write, cur.wr);
          chkb("grant_rd", bus.pmem_read, !cur.wr);
          if (cur.wr) chk("grant_wdata", bus.pmem_wdata, cur.wdata);
        end
      end
      if (stb) begin
        stb_len++;
        chka("addr_hold", bus.pmem_address, cur.addr);
        if (cur.wr) chk("wdata_hold", bus.pmem_wdata, cur.wdata);
        chkb("i_resp_route", bus.i_resp, bus.pmem_resp & !cur.is_d);
        chkb("d_resp_route", bus.d_resp, bus.pmem_resp & cur.is_d);
        if (bus.pmem_resp) begin
          if (cur.is_d) begin
            chk("d_rdata", bus.d_rdata, mem_data);
            last_rdata = bus.d_rdata;
            d_cnt++;
          end else begin
            chk("i_rdata", bus.i_rdata, mem_data);
            last_rdata = bus.i_rdata;
            i_cnt++;
          end
          last_len  = stb_len;
          need_idle = 1'b1;
        end
      end else begin
        chkb("idle_no_i_resp", bus.i_resp, 1'b0);
        chkb("idle_no_d_resp", bus.d_resp, 1'b0);
      end
      prev_stb = stb;
    end
  end

  // One clock; inputs change 1 time unit after the edge. Also runs the memory model.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;
    if (mem_en && (bus.pmem_read || bus.pmem_write)) begin
      if (mem_cnt == 0) mem_lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_data = force_data_en ? force_data
                                 : {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.pmem_rdata = mem_data;
        bus.pmem_resp  = 1'b1;
        mem_cnt        = 0;
      end
    end
  endtask

  task automatic push_d(logic dw, logic [AW-1:0] da, logic [LW-1:0] dwd);
    exp_t e;
    e.is_d = 1'b1; e.wr = dw; e.addr = da; e.wdata = dwd;
    expq.push_back(e);
  endtask

  task automatic push_i(logic [AW-1:0] ia);
    exp_t e;
    e.is_d = 1'b0; e.wr = 1'b0; e.addr = ia; e.wdata = '0;
    expq.push_back(e);
  endtask

  // Raise a set of requests together, hold each until its response, then drop.
  task automatic run_episode(logic ri, logic dr, logic dw, logic [AW-1:0] ia,
                             logic [AW-1:0] da, logic [LW-1:0] dwd);
    logic dq, d_first, rr;
    int   i0, d0, guard;
    dq = dr | dw;
    if (!ri && !dq) return;
`ifdef ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    if (ri && dq) d_first = rr ? m_last_i : 1'b1;
    else          d_first = dq;
    if (d_first) begin
      push_d(dw, da, dwd);
      if (ri) push_i(ia);
      m_last_i = ri;
    end else begin
      push_i(ia);
      if (dq) push_d(dw, da, dwd);
      m_last_i = !dq;
    end
    i0 = i_cnt; d0 = d_cnt;
    bus.i_read = ri; bus.i_addr = ia;
    bus.d_read = dr; bus.d_write = dw; bus.d_addr = da; bus.d_wdata = dwd;
    tick();
    chkb("grant_latency", bus.pmem_read | bus.pmem_write, 1'b1);
    guard = 0;
    while (guard < 100) begin
      if (i_cnt != i0) bus.i_read = 1'b0;
      if (d_cnt != d0) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      if (!(bus.i_read | bus.d_read | bus.d_write)) break;
      // Latched writeback data must ignore later d_wdata changes.
      if (d_first && d_cnt == d0) bus.d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      guard++;
    end
    chkb("episode_timeout", guard >= 100, 1'b0);
    tick();
    chki("queue_drained", expq.size(), 0);
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ri, dr, dw;
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    tick(); tick();
    chkb("rst_pmem_read",  bus.pmem_read,  1'b0);
    chkb("rst_pmem_write", bus.pmem_write, 1'b0);
    chkb("rst_i_resp",     bus.i_resp,     1'b0);
    chkb("rst_d_resp",     bus.d_resp,     1'b0);
    chka("rst_pmem_address", bus.pmem_address, '0);
    chk("rst_pmem_wdata",  bus.pmem_wdata, '0);
    rst_n = 1'b1; mon_en = 1'b1; mem_en = 1'b1;
    tick();

    // Conflict straight out of reset: D first, then I.
    run_episode(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200, '0);

    // Icache read with 3-cycle memory and a fixed line.
    force_lat = 3; force_data_en = 1'b1; force_data = {16{8'hA5}};
    run_episode(1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, '0);
    chki("i_read_strobe_len", last_len, 3);
    chk("i_rdata_a5", last_rdata, {16{8'hA5}});
    force_lat = 0; force_data_en = 1'b0;

    // Dcache writeback; d_wdata is scrambled during the transaction.
    run_episode(1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Read and write together is a write.
    run_episode(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010, 128'hDEADBEEF);

    // Further conflicts exercise the policy (RR alternates, fixed keeps D first).
    run_episode(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0400, '0);
    run_episode(1'b1, 1'b0, 1'b1, 16'h0500, 16'h0600, 128'h55);

    for (int k = 0; k < 40; k++) begin
      ri = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      if (!ri && !dr && !dw) ri = 1'b1;
      run_episode(ri, dr, dw, 16'($urandom), 16'($urandom),
                  {$urandom(), $urandom(), $urandom(), $urandom()});
      repeat ($urandom_range(0, 2)) tick();
    end

    // Directed: reset in the middle of an icache read with pmem_resp in that cycle.
    mon_en = 1'b0; mem_en = 1'b0;
    tick();
    bus.i_read = 1'b1; bus.i_addr = 16'h2468;
    tick();
    chkb("rst_mid_grant", bus.pmem_read, 1'b1);
    chka("rst_mid_addr", bus.pmem_address, 16'h2468);
    tick();
    rst_n = 1'b0; bus.pmem_resp = 1'b1; bus.pmem_rdata = 128'h77;
    #1;
    chkb("rst_mid_no_i_resp", bus.i_resp, 1'b0);
    tick();
    chkb("rst_mid_rd_low", bus.pmem_read, 1'b0);
    chkb("rst_mid_wr_low", bus.pmem_write, 1'b0);
    chka("rst_mid_addr_clr", bus.pmem_address, '0);
    rst_n = 1'b1; bus.i_addr = 16'h1357;
    tick();
    chkb("regrant_rd", bus.pmem_read, 1'b1);
    chka("regrant_addr", bus.pmem_address, 16'h1357);
    bus.pmem_rdata = 128'hCAFE; bus.pmem_resp = 1'b1;
    #1;
    chkb("regrant_i_resp", bus.i_resp, 1'b1);
    chkb("regrant_no_d_resp", bus.d_resp, 1'b0);
    chk("regrant_i_rdata", bus.i_rdata, 128'hCAFE);
    tick();
    bus.i_read = 1'b0;
    chkb("regrant_done", bus.pmem_read, 1'b0);
    tick();

    // Directed: spurious pmem_resp while idle.
    bus.pmem_resp = 1'b1;
    #1;
    chkb("spur_no_i_resp", bus.i_resp, 1'b0);
    chkb("spur_no_d_resp", bus.d_resp, 1'b0);
    tick();
    chkb("spur_idle_rd", bus.pmem_read, 1'b0);
    chkb("spur_idle_wr", bus.pmem_write, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbiter sharing the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core. The fetch and memory stages stall on cache misses until their `*_resp` arrives. This block picks one pending cache request, latches its address and write data, and drives one pmem transaction. It then routes `pmem_resp`/`pmem_rdata` back to the granted cache only. It sits between the two caches and physical memory.

## Interface
- `ADDR_W`, 16: address width (lc3b_word).
- `LINE_W`, 128: cache line width in bits.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `i_read`  in  1  icache line read request; level, held until `i_resp`.
- `i_addr`  in  ADDR_W  icache line address.
- `i_rdata`  out  LINE_W  line data to icache, valid with `i_resp`.
- `i_resp`  out  1  icache transaction complete, one-cycle pulse.
- `d_read`  in  1  dcache line read request; level, held until `d_resp`.
- `d_write`  in  1  dcache line writeback request; level, held until `d_resp`.
- `d_addr`  in  ADDR_W  dcache line address.
- `d_wdata`  in  LINE_W  dcache writeback data.
- `d_rdata`  out  LINE_W  line data to dcache, valid with `d_resp`.
- `d_resp`  out  1  dcache transaction complete, one-cycle pulse.
- `pmem_read`  out  1  physical-memory read strobe.
- `pmem_write`  out  1  physical-memory write strobe.
- `pmem_address`  out  ADDR_W  latched transaction address.
- `pmem_wdata`  out  LINE_W  latched writeback data.
- `pmem_rdata`  in  LINE_W  memory read data, valid with `pmem_resp`.
- `pmem_resp`  in  1  memory transaction done.

## Operation
- FSM states:
  - IDLE: no transaction.
  - GRANT_I: icache owns the port.
  - GRANT_D: dcache owns the port.
- IDLE, no request pending: stay in IDLE.
- IDLE, exactly one cache requesting: go to that cache's grant state next edge.
- IDLE, both caches requesting: resolve by the arbitration policy (see Configuration).
- Entering a grant state latches:
  - the owner's address into `pmem_address`;
  - `d_wdata` into `pmem_wdata`, for dcache writes only;
  - the op type (read/write) into an op register.
- Latched values do not change for the whole transaction.
- `pmem_read`/`pmem_write` are decoded from state and op register only:
  - both 0 in IDLE;
  - exactly one is 1 in a grant state.
- `d_read` and `d_write` both high: treated as a write.
- In GRANT_x, `pmem_resp`=1:
  - `x_resp`=1 combinationally in the same cycle;
  - `x_rdata`=`pmem_rdata`;
  - FSM returns to IDLE next edge.
- The non-owner's `*_resp` is always 0.
- `i_rdata`/`d_rdata` continuously mirror `pmem_rdata`. They are meaningful only with their `*_resp`.
- `pmem_resp` in IDLE is ignored: no `*_resp`, no state change.
- A requester dropping its request mid-grant does not abort the transaction. The arbiter waits for `pmem_resp` and pulses `*_resp` regardless.
- Reset values:
  - state IDLE;
  - `pmem_read`=0, `pmem_write`=0, `i_resp`=0, `d_resp`=0;
  - `pmem_address`=0, `pmem_wdata`=0;
  - last-granted flag = I (so the first conflict goes to D).

## Timing
- Request-to-strobe latency: request visible at edge N → state GRANT_x and `pmem_*` strobe high from edge N+1.
- Response: `x_resp` is in the same cycle as `pmem_resp`. Strobe is low from the next edge.
- One mandatory IDLE cycle between back-to-back transactions. A held second request is granted at edge after the IDLE cycle.
- Minimum transaction: 3 cycles from request to next possible grant when memory responds in 1 cycle.
- `rst_n` low at any edge: next state IDLE and strobes 0, overriding an in-flight transaction. A `pmem_resp` arriving in the reset cycle produces no `*_resp`.

## Configuration
- `ARB_RR_EN` defined: round-robin on conflict.
  - The cache not granted last wins.
  - The last-granted flag updates on every grant.
- `ARB_RR_EN` undefined: fixed priority.
  - dcache always wins a conflict.
  - Last-granted flag not implemented.

## Test plan
- Icache read only: `i_read`=1, `i_addr`=0x1230; memory responds 3 cycles after strobe with 0xA5..A5.
  - Required: `pmem_read`=1, `pmem_address`=0x1230 for 3 cycles.
  - Required: `i_resp` one pulse with `i_rdata`=0xA5..A5; `d_resp` stays 0.
- Dcache writeback: `d_write`=1, `d_addr`=0x4000, `d_wdata`=0x0123..EF.
  - Required: `pmem_write`=1, `pmem_wdata`=0x0123..EF, `pmem_read`=0.
  - Required: `d_resp` pulse; `pmem_wdata` unchanged even if `d_wdata` toggles mid-transaction.
- Simultaneous `i_read` and `d_read` out of reset, both held.
  - Required: D granted first, then one IDLE cycle, then I granted.
  - With `ARB_RR_EN`, a third conflict is granted to D. Without it, dcache is granted on every conflict.
- Dcache read and write both high, `d_addr`=0x0010.
  - Required: `pmem_write`=1, `pmem_read`=0.
- Reset mid-transaction: `rst_n`=0 two cycles into an icache read, with `pmem_resp`=1 in the same cycle.
  - Required: `i_resp`=0, next state IDLE, strobes 0.
  - Required: after `rst_n`=1, the held `i_read` is regranted with a fresh latch.
- Spurious `pmem_resp`=1 while IDLE.
  - Required: no `*_resp`, state stays IDLE.
